// File: rtl/sa_seq_ctrl.sv
// rtl/sa_seq_ctrl.sv - weight-stationary systolic array sequencer (load, skewed stream, result valids)
// Optional weight reuse (IDLE -> COMP when weights are still resident) enabled by SC_WEIGHT_REUSE_EN.
module sa_seq_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int VEC_W = 8
) (
  input  logic                    SC_clk,
  input  logic                    SC_rst_n,
  input  logic                    SC_start,
  input  logic [VEC_W-1:0]        SC_num_vec,
  input  logic                    SC_abort,
`ifdef SC_WEIGHT_REUSE_EN
  input  logic                    SC_reuse,
`endif
  output logic                    SC_busy,
  output logic                    SC_done,
  output logic                    SC_wt_rd_en,
  output logic [$clog2(ROWS)-1:0] SC_wt_rd_row,
  output logic                    SC_arr_mode,
  output logic                    SC_arr_en_top,
  output logic [ROWS-1:0]         SC_act_en,
  output logic [ROWS*VEC_W-1:0]   SC_act_idx,
  output logic [COLS-1:0]         SC_res_valid
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = VEC_W + $clog2(ROWS + COLS) + 1;
  localparam logic [CW-1:0] LOAD_LAST = CW'(ROWS - 1);
  localparam logic [CW-1:0] SKEW      = CW'(ROWS + COLS - 2);

  typedef enum logic [1:0] {IDLE, LOAD, COMP, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [VEC_W-1:0]  num_vec_q, num_vec_n;
  logic [CW-1:0]     comp_last;
  logic signed [CW:0] nv_s;
  logic              reuse_ok;

  assign comp_last = CW'(num_vec_q) + SKEW;
  assign nv_s      = $signed({1'b0, CW'(num_vec_q)});

`ifdef SC_WEIGHT_REUSE_EN
  logic wt_valid;

  // Weights stay resident after a complete LOAD; a LOAD cut short leaves them partial.
  always_ff @(posedge SC_clk) begin
    if (!SC_rst_n) begin
      wt_valid <= 1'b0;
    end else if (state == LOAD) begin
      if (SC_abort)
        wt_valid <= 1'b0;
      else if (cnt == LOAD_LAST)
        wt_valid <= 1'b1;
    end
  end

  assign reuse_ok = SC_reuse & wt_valid;
`else
  assign reuse_ok = 1'b0;
`endif

  always_ff @(posedge SC_clk) begin
    if (!SC_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      num_vec_q <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      num_vec_q <= num_vec_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    num_vec_n = num_vec_q;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (SC_start) begin
          num_vec_n = SC_num_vec;
          if (!reuse_ok)
            state_n = LOAD;
          else if (SC_num_vec == '0)
            state_n = DONE;
          else
            state_n = COMP;
        end
      end
      LOAD: begin
        if (cnt == LOAD_LAST) begin
          cnt_n   = '0;
          state_n = (num_vec_q == '0) ? DONE : COMP;
        end
      end
      COMP: begin
        if (cnt == comp_last) begin
          cnt_n   = '0;
          state_n = DONE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
    // Abort outranks every transition but never cancels a start seen in IDLE.
    if (SC_abort && state != IDLE) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  always_comb begin
    logic signed [CW:0] d;
    d             = '0;
    SC_busy       = (state != IDLE);
    SC_done       = (state == DONE);
    SC_wt_rd_en   = 1'b0;
    SC_wt_rd_row  = '0;
    SC_arr_mode   = 1'b0;
    SC_arr_en_top = 1'b0;
    SC_act_en     = '0;
    SC_act_idx    = '0;
    SC_res_valid  = '0;
    if (state == LOAD) begin
      SC_wt_rd_en   = 1'b1;
      SC_wt_rd_row  = RW'(ROWS - 1) - cnt[RW-1:0];
      SC_arr_mode   = 1'b1;
      SC_arr_en_top = 1'b1;
    end
    if (state == COMP) begin
      // Row r sees vector cnt-r; signed difference keeps early cycles from wrapping.
      for (int r = 0; r < ROWS; r++) begin
        d = $signed({1'b0, cnt}) - $signed((CW+1)'(r));
        if (d >= 0 && d < nv_s) begin
          SC_act_en[r]                  = 1'b1;
          SC_act_idx[r*VEC_W +: VEC_W]  = d[VEC_W-1:0];
        end
      end
      for (int c = 0; c < COLS; c++) begin
        d = $signed({1'b0, cnt}) - $signed((CW+1)'(ROWS + c));
        if (d >= 0 && d < nv_s)
          SC_res_valid[c] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// tb/tb_sa_seq_ctrl.sv - scoreboard bench for sa_seq_ctrl (ROWS=COLS=4, VEC_W=8)
module tb_sa_seq_ctrl;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int VEC_W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        reuse = 1'b0;
  logic [7:0]  num_vec = '0;
  logic        sc_busy, sc_done, sc_wt_rd_en, sc_arr_mode, sc_arr_en_top;
  logic [1:0]  sc_wt_rd_row;
  logic [3:0]  sc_act_en, sc_res_valid;
  logic [31:0] sc_act_idx;

  sa_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .VEC_W(VEC_W)) dut (
    .SC_clk(clk), .SC_rst_n(rst_n), .SC_start(start), .SC_num_vec(num_vec),
    .SC_abort(abort),
`ifdef SC_WEIGHT_REUSE_EN
    .SC_reuse(reuse),
`endif
    .SC_busy(sc_busy), .SC_done(sc_done), .SC_wt_rd_en(sc_wt_rd_en),
    .SC_wt_rd_row(sc_wt_rd_row), .SC_arr_mode(sc_arr_mode), .SC_arr_en_top(sc_arr_en_top),
    .SC_act_en(sc_act_en), .SC_act_idx(sc_act_idx), .SC_res_valid(sc_res_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [1:0]  row;
    logic        mode;
    logic        top;
    logic [3:0]  act_en;
    logic [31:0] idx;
    logic [3:0]  res;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   busy_cyc = 0;
  int   done_cnt = 0;
  bit   mon_on = 1'b0;

  function automatic obs_t sample();
    obs_t a;
    a.busy = sc_busy; a.done = sc_done; a.rd_en = sc_wt_rd_en; a.row = sc_wt_rd_row;
    a.mode = sc_arr_mode; a.top = sc_arr_en_top; a.act_en = sc_act_en;
    a.idx = sc_act_idx; a.res = sc_res_valid;
    return a;
  endfunction

  // Monitor: every busy cycle consumes one expected record; idle cycles must be all-zero.
  always @(negedge clk) begin
    obs_t a, e;
    if (mon_on) begin
      a = sample();
      total++;
      if (a.busy) begin
        busy_cyc++;
        if (a.done) done_cnt++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_busy act=%h req=idle", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            bad++;
            $display("FAIL cycle_outputs act=%h req=%h", a, e);
          end
        end
      end else if (a !== '0) begin
        bad++;
        $display("FAIL idle_outputs act=%h req=0", a);
      end
    end
  end

  // Expected per-cycle outputs: vector k reaches row r at COMP cycle k+r, column c at k+ROWS+c.
  task automatic push_run(input int nv, input bit do_load, input int cut);
    obs_t seq[$];
    obs_t comp[];
    obs_t e;
    int   t;
    if (do_load)
      for (int i = 0; i < ROWS; i++) begin
        e = '0; e.busy = 1'b1; e.rd_en = 1'b1; e.row = 2'(ROWS - 1 - i);
        e.mode = 1'b1; e.top = 1'b1;
        seq.push_back(e);
      end
    if (nv > 0) begin
      t = nv + ROWS + COLS - 1;
      comp = new[t];
      foreach (comp[i]) begin
        comp[i] = '0;
        comp[i].busy = 1'b1;
      end
      for (int k = 0; k < nv; k++) begin
        for (int r = 0; r < ROWS; r++) begin
          comp[k+r].act_en[r] = 1'b1;
          comp[k+r].idx[r*VEC_W +: VEC_W] = 8'(k);
        end
        for (int c = 0; c < COLS; c++)
          comp[k+ROWS+c].res[c] = 1'b1;
      end
      foreach (comp[i]) seq.push_back(comp[i]);
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1;
    seq.push_back(e);
    for (int i = 0; i < seq.size(); i++)
      if (cut < 0 || i < cut) exp_q.push_back(seq[i]);
  endtask

  task automatic do_start(input int nv, input bit ru);
    @(posedge clk); #1 start = 1'b1; num_vec = 8'(nv); reuse = ru;
    @(posedge clk); #1 start = 1'b0; reuse = 1'b0;
  endtask

  task automatic pulse_start(input int nv);
    start = 1'b1; num_vec = 8'(nv);
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic abort_after(input int n);
    repeat (n) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(posedge clk); #2;
    while ((exp_q.size() != 0 || sc_busy) && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL %s_timeout act=queue:%0d busy:%0b req=drained", name, exp_q.size(), sc_busy);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_counts(input string name, input int exp_busy, input int exp_done);
    total++;
    if (busy_cyc != exp_busy) begin
      bad++;
      $display("FAIL %s_busy_cycles act=%0d req=%0d", name, busy_cyc, exp_busy);
    end
    total++;
    if (done_cnt != exp_done) begin
      bad++;
      $display("FAIL %s_done_pulses act=%0d req=%0d", name, done_cnt, exp_done);
    end
    busy_cyc = 0;
    done_cnt = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1);
  end

  initial begin
    obs_t r;
    int   n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    r = sample();
    total++;
    if (r !== '0) begin
      bad++;
      $display("FAIL reset_outputs act=%h req=0", r);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    mon_on = 1'b1;

    // Basic run: 4 LOAD + 10 COMP + DONE.
    do_start(3, 1'b0); push_run(3, 1'b1, -1);
    drain("nv3"); check_counts("nv3", 15, 1);

    // Zero vectors: LOAD straight to DONE.
    do_start(0, 1'b0); push_run(0, 1'b1, -1);
    drain("nv0"); check_counts("nv0", 5, 1);

    // Abort during COMP cycle 2, then a fresh full run.
    do_start(3, 1'b0); push_run(3, 1'b1, 7);
    abort_after(6);
    do_start(3, 1'b0); push_run(3, 1'b1, -1);
    drain("abort"); check_counts("abort", 22, 1);

    // Starts during LOAD and COMP must not disturb the run.
    do_start(3, 1'b0); push_run(3, 1'b1, -1);
    pulse_start(7);
    repeat (5) @(posedge clk);
    #1 pulse_start(7);
    drain("busy_start"); check_counts("busy_start", 15, 1);

    // Maximum vector count: COMP lasts 262 cycles.
    do_start(255, 1'b0); push_run(255, 1'b1, -1);
    drain("nv255"); check_counts("nv255", 267, 1);

    // Back-to-back: start in the IDLE cycle right after DONE.
    do_start(1, 1'b0); push_run(1, 1'b1, -1);
    n = 0;
    @(negedge clk);
    while (!sc_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    do_start(2, 1'b0); push_run(2, 1'b1, -1);
    drain("b2b"); check_counts("b2b", 27, 2);

    // Reset mid-run behaves like power-on reset.
    do_start(3, 1'b0); push_run(3, 1'b1, 6);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    drain("mid_reset"); check_counts("mid_reset", 6, 0);

`ifdef SC_WEIGHT_REUSE_EN
    do_start(2, 1'b1); push_run(2, 1'b1, -1);
    drain("reuse_first"); check_counts("reuse_first", 14, 1);
    do_start(2, 1'b1); push_run(2, 1'b0, -1);
    drain("reuse_hit"); check_counts("reuse_hit", 10, 1);
    do_start(2, 1'b0); push_run(2, 1'b1, 2);
    abort_after(1);
    do_start(2, 1'b1); push_run(2, 1'b1, -1);
    drain("reuse_abort"); check_counts("reuse_abort", 16, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
